opl_write_queue: RTL
====================

Name: opl_write_queue

Overview:
- Upstream stage for the OPL3 core wrapper.
- Accepts single-cycle CPU register writes (index/data) from the C64 expansion-port decode and buffers them in a small FIFO.
- Replays the writes to the OPL3 core at a paced rate: a rising-edge write strobe, then a minimum inter-write gap that depends on write type, matching OPL register-access timing.
- Status reads pass through unchanged.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 2..64.
- WE_LEN, 2, cycles that opl_we is held high per replayed write; must be >= 1.
- INDEX_GAP, 8, idle cycles after an index write (opl_addr[0]=0); must be >= 1.
- DATA_GAP, 64, idle cycles after a data write (opl_addr[0]=1); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_we  in  1  one-cycle write strobe from the I/O decode.
- cpu_addr  in  2  register port: bit0=0 index, bit0=1 data; bit1 selects bank.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data; combinational copy of opl_dout.
- opl_dout  in  8  status byte from the OPL3 core.
- opl_addr  out  2  replayed port address, registered.
- opl_din  out  8  replayed data, registered.
- opl_we  out  1  replayed write strobe, registered; the consumer edge-detects its rising edge.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- full  out  1  FIFO count == DEPTH.
- overflow  out  1  sticky: a write was dropped because the FIFO was full; cleared only by reset.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - opl_we=0, opl_addr=0, opl_din=0, overflow=0.
  - FIFO emptied (count=0, pointers=0); FSM to IDLE; gap counter=0.
  - Any half-replayed write is abandoned and not retried.
- Push:
  - On cpu_we=1 with count<DEPTH, {cpu_addr, cpu_din} is written at the write pointer and count increments.
  - full and count are judged on registered values. With count==DEPTH, a push is rejected even if a pop occurs in the same cycle; overflow is set.
  - A simultaneous push and pop with count<DEPTH leaves count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- FSM states: IDLE, STROBE, GAP.
  - IDLE: if count>0, pop the head entry, load opl_addr/opl_din, set opl_we=1, load the strobe counter with WE_LEN-1, go to STROBE.
  - STROBE: opl_we held at 1. When the counter reaches 0: opl_we=0, load the gap counter with (opl_addr[0] ? DATA_GAP : INDEX_GAP)-1, go to GAP. Otherwise decrement.
  - GAP: opl_we=0. When the counter reaches 0, go to IDLE. Otherwise decrement.
  - opl_addr/opl_din hold their last values outside STROBE.
- Latency, empty FIFO:
  - cpu_we in cycle 0 → entry stored at the edge ending cycle 0.
  - FSM pops at the edge ending cycle 1 → opl_we=1 during cycles 2..(1+WE_LEN).
- Write spacing:
  - Rising edges of opl_we are spaced exactly WE_LEN+gap+1 cycles apart when the FIFO stays non-empty. The +1 is the IDLE pop cycle.
  - opl_we is low for at least one cycle between writes, so the consumer never misses an edge.
- Ordering: strict FIFO order; no reordering or merging of writes.
- busy=0 only when count==0 and the FSM is in IDLE.

Decomposition:
- Package opl_wq_pkg:
  - typedef wq_entry_t {logic [1:0] addr; logic [7:0] data;}.
  - enum wq_state_t {IDLE, STROBE, GAP}.
  - function gap_len(addr).
- Sub-module opl_wq_fifo:
  - Synchronous single-clock FIFO of wq_entry_t, DEPTH entries.
  - Ports: push, pop, wdata, rdata, count, full, empty; async reset.
  - The top level contains only the FSM, counters and overflow flag.

Test Plan:
- Reset values: assert rst_n=0 for 3 cycles → opl_we=0, busy=0, full=0, overflow=0, opl_addr=0, opl_din=0.
- Single write, defaults: cpu_we with addr=0, din=0x04 at cycle 0 → opl_we=1 in cycles 2-3, opl_addr=0, opl_din=0x04; next pop no earlier than cycle 12; busy falls at cycle 12.
- Pair spacing: index 0xB0 then data 0x31 on back-to-back cycles → opl_we rising edges at cycles 2 and 13 (2+8+1); data write sequence ends with busy=0 after a further 2+64 cycles.
- Overflow: 18 back-to-back writes at defaults → the first write pops at cycle 1, so 17 are accepted, the 18th is dropped; overflow=1; exactly 17 strobes emerge, in order, with matching data.
- Wrap: 40 writes spaced 100 cycles apart with DEPTH=4 → all 40 replayed in order; count never exceeds 1.
- Reset mid-strobe: rst_n low while opl_we=1 → opl_we=0 in the same cycle without waiting for a clock; after release the queue is empty, no residual strobes occur, and overflow=0.

Source files
------------

// File: rtl/opl_wq_pkg.sv
// Shared types for the OPL write queue: FIFO entry, replay FSM states and
// the post-write gap selection.
package opl_wq_pkg;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } wq_state_t;

  // Data-port writes need the long settle time, index-port writes the short one.
  function automatic int unsigned gap_len(input logic [1:0] addr,
                                          input int unsigned index_gap,
                                          input int unsigned data_gap);
    return addr[0] ? data_gap : index_gap;
  endfunction

endpackage

// File: rtl/opl_write_queue_if.sv
// CPU-side register bus into the write queue: write strobe, port, data and
// the status byte read back from the OPL core.
interface opl_write_queue_if;
  logic       cpu_we;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (output cpu_we, output cpu_addr, output cpu_din, input cpu_dout);
  modport slave  (input cpu_we, input cpu_addr, input cpu_din, output cpu_dout);
endinterface

// File: rtl/opl_wq_fifo.sv
// Single-clock FIFO of queued register writes; push while full and pop while
// empty are ignored, full/empty come from the registered count.
module opl_wq_fifo
  import opl_wq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wq_entry_t                wdata,
  output wq_entry_t                rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  wq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) wide, so the increment wraps for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opl_write_queue.sv
// Buffers CPU register writes and replays them to the OPL3 core as a WE_LEN
// strobe followed by an index/data dependent idle gap.
module opl_write_queue
  import opl_wq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WE_LEN    = 2,
  parameter int INDEX_GAP = 8,
  parameter int DATA_GAP  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  opl_write_queue_if.slave      cpu,
  input  logic [7:0]            opl_dout,
  output logic [1:0]            opl_addr,
  output logic [7:0]            opl_din,
  output logic                  opl_we,
  output logic                  busy,
  output logic                  full,
  output logic                  overflow
);

  localparam int CNT_MAX = (WE_LEN > INDEX_GAP)
                         ? ((WE_LEN > DATA_GAP) ? WE_LEN : DATA_GAP)
                         : ((INDEX_GAP > DATA_GAP) ? INDEX_GAP : DATA_GAP);
  localparam int CW = $clog2(CNT_MAX + 1);

  wq_state_t               state;
  wq_state_t               state_d;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_d;
  logic                    we_d;
  logic [1:0]              addr_d;
  logic [7:0]              din_d;
  logic                    pop;
  wq_entry_t               head;
  wq_entry_t               wdata;
  logic [$clog2(DEPTH):0]  count;
  logic                    fifo_full;
  logic                    empty;

  assign cpu.cpu_dout = opl_dout;
  assign wdata        = '{addr: cpu.cpu_addr, data: cpu.cpu_din};

  opl_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cpu.cpu_we),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opl_we   <= 1'b0;
      opl_addr <= '0;
      opl_din  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      opl_we   <= we_d;
      opl_addr <= addr_d;
      opl_din  <= din_d;
      if (cpu.cpu_we && fifo_full) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!empty)      state_d = STROBE;
      STROBE:  if (cnt == '0)   state_d = GAP;
      GAP:     if (cnt == '0)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // The gap length is chosen from opl_addr, which still holds the entry being replayed.
  always_comb begin
    pop    = 1'b0;
    cnt_d  = cnt;
    we_d   = opl_we;
    addr_d = opl_addr;
    din_d  = opl_din;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          we_d   = 1'b1;
          addr_d = head.addr;
          din_d  = head.data;
          cnt_d  = CW'(WE_LEN - 1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          we_d  = 1'b0;
          cnt_d = CW'(gap_len(opl_addr, INDEX_GAP, DATA_GAP) - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        we_d = 1'b0;
        if (cnt != '0) cnt_d = cnt - CW'(1);
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  assign busy = (count != '0) || (state != IDLE);
  assign full = fifo_full;

endmodule
